// File: rtl/writeback_queue.sv
// ============================================================================
// Module  : writeback_queue
// Purpose : Register-file writeback FIFO with trap hold, flush and optional
//           youngest-match forwarding (enable with COTM32_WBQ_FWD_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package writeback_queue_pkg;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;
endpackage

module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int N_REGS = NUM_REGS
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [$clog2(N_REGS)-1:0]    i_rd,
    input  logic [XLEN-1:0]              i_data,
    input  logic                         i_trap_req,
    input  logic                         i_flush,
    output logic                         o_we,
    output logic [$clog2(N_REGS)-1:0]    o_waddr,
    output logic [XLEN-1:0]              o_wdata,
    output logic [$clog2(DEPTH):0]       o_count,
    input  logic [$clog2(N_REGS)-1:0]    i_fwd_addr,
    output logic                         o_fwd_hit,
    output logic [XLEN-1:0]              o_fwd_data
);

    localparam int AW = $clog2(N_REGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   r_rd_mem   [DEPTH];
    logic [XLEN-1:0] r_data_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_not_empty;
    logic w_push;
    logic w_pop;

    assign w_not_empty = (r_count != '0);
    assign o_ready     = (r_count < CW'(DEPTH));
    assign o_we        = w_not_empty & ~i_trap_req & ~i_flush;
    assign w_pop       = o_we;
    // rd == 0 offers complete the handshake but are dropped here
    assign w_push      = i_valid & o_ready & ~i_flush & (i_rd != '0);
    assign o_count     = r_count;
    assign o_waddr     = w_not_empty ? r_rd_mem[r_rd_ptr]   : '0;
    assign o_wdata     = w_not_empty ? r_data_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_rd_mem[r_wr_ptr]   <= i_rd;
            r_data_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef COTM32_WBQ_FWD_EN
    logic            w_fwd_hit;
    logic [XLEN-1:0] w_fwd_data;

    // Scan oldest to youngest so the youngest match wins
    always_comb begin
        logic [PW-1:0] idx;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_rd_ptr + PW'(k);
            if ((CW'(k) < r_count) && (i_fwd_addr != '0) &&
                (r_rd_mem[idx] == i_fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data_mem[idx];
            end
        end
    end

    assign o_fwd_hit  = w_fwd_hit;
    assign o_fwd_data = w_fwd_data;
`else
    logic w_fwd_unused;
    assign w_fwd_unused = ^i_fwd_addr;
    assign o_fwd_hit    = 1'b0;
    assign o_fwd_data   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ============================================================================
// Module  : tb_writeback_queue
// Purpose : Directed plus random check of writeback_queue against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(NUM_REGS);
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid, i_trap_req, i_flush;
    logic [AW-1:0]   i_rd, i_fwd_addr;
    logic [XLEN-1:0] i_data;
    logic            o_ready, o_we, o_fwd_hit;
    logic [AW-1:0]   o_waddr;
    logic [XLEN-1:0] o_wdata, o_fwd_data;
    logic [CW-1:0]   o_count;

    int     checks = 0;
    int     errors = 0;
    entry_t model_q[$];

    writeback_queue #(.DEPTH(DEPTH), .N_REGS(NUM_REGS)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rd       (i_rd),
        .i_data     (i_data),
        .i_trap_req (i_trap_req),
        .i_flush    (i_flush),
        .o_we       (o_we),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_count    (o_count),
        .i_fwd_addr (i_fwd_addr),
        .o_fwd_hit  (o_fwd_hit),
        .o_fwd_data (o_fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the model for the currently driven inputs
    task automatic check_outputs();
        logic            e_hit;
        logic [XLEN-1:0] e_fdata;
        int              n;
        n       = model_q.size();
        e_hit   = 1'b0;
        e_fdata = '0;
`ifdef COTM32_WBQ_FWD_EN
        if (i_fwd_addr != 0) begin
            for (int j = n - 1; j >= 0; j--) begin
                if (model_q[j].rd == i_fwd_addr) begin
                    e_hit   = 1'b1;
                    e_fdata = model_q[j].data;
                    break;
                end
            end
        end
`endif
        chk("count", 64'(o_count), 64'(n));
        chk("ready", 64'(o_ready), 64'(n < DEPTH));
        chk("we",    64'(o_we),    64'((n != 0) && !i_trap_req && !i_flush));
        chk("waddr", 64'(o_waddr), (n != 0) ? 64'(model_q[0].rd)   : 64'd0);
        chk("wdata", 64'(o_wdata), (n != 0) ? 64'(model_q[0].data) : 64'd0);
        chk("fwd_hit",  64'(o_fwd_hit),  64'(e_hit));
        chk("fwd_data", 64'(o_fwd_data), 64'(e_fdata));
    endtask

    // One cycle: drive at negedge, check, advance model, cross posedge
    task automatic step(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                        input logic trap, input logic fl, input logic [AW-1:0] fa);
        bit acc, wr;
        @(negedge clk);
        i_valid = v; i_rd = rd; i_data = d;
        i_trap_req = trap; i_flush = fl; i_fwd_addr = fa;
        #1;
        check_outputs();
        acc = v && (model_q.size() < DEPTH);
        wr  = (model_q.size() != 0) && !trap && !fl;
        if (fl) begin
            model_q.delete();
        end else begin
            if (wr) void'(model_q.pop_front());
            if (acc && rd != 0) model_q.push_back('{rd: rd, data: d});
        end
        @(posedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_we",    64'(o_we),    64'd0);
        chk("rst_waddr", 64'(o_waddr), 64'd0);
        chk("rst_wdata", 64'(o_wdata), 64'd0);
        chk("rst_fhit",  64'(o_fwd_hit),  64'd0);
        chk("rst_fdata", 64'(o_fwd_data), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_valid = 0; i_rd = '0; i_data = '0;
        i_trap_req = 0; i_flush = 0; i_fwd_addr = '0;
        #2;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Single push then drain
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5);
        step(0, 5'd0, 32'h0, 0, 0, 5'd5);
        step(0, 5'd0, 32'h0, 0, 0, 5'd0);

        // Trap held while filling; then drain in order
        for (int i = 1; i <= 4; i++) step(1, AW'(i), 32'h100 + i, 1, 0, AW'(i));
        step(1, 5'd9, 32'h999, 1, 0, 5'd3);
        for (int i = 0; i < 5; i++) step(0, 5'd0, 32'h0, 0, 0, 5'd0);

        // rd == 0 offer is accepted but dropped
        step(1, 5'd0, 32'h1234, 0, 0, 5'd0);
        step(0, 5'd0, 32'h0, 0, 0, 5'd0);

        // Forwarding: youngest match wins
        step(1, 5'd7, 32'h11, 1, 0, 5'd7);
        step(1, 5'd7, 32'h22, 1, 0, 5'd7);
        step(0, 5'd0, 32'h0, 1, 0, 5'd7);
        step(0, 5'd0, 32'h0, 1, 0, 5'd0);

        // Flush with a concurrent offer
        step(1, 5'd3, 32'h33, 1, 0, 5'd3);
        step(1, 5'd4, 32'h44, 1, 1, 5'd3);
        step(0, 5'd0, 32'h0, 0, 0, 5'd4);

        // Asynchronous reset mid-drain at count 2
        for (int i = 1; i <= 3; i++) step(1, AW'(i + 10), 32'hA0 + i, 1, 0, 5'd0);
        step(0, 5'd0, 32'h0, 0, 0, 5'd0);
        @(negedge clk);
        i_valid = 0; i_trap_req = 0; i_flush = 0;
        #1;
        chk("pre_rst_count", 64'(o_count), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0),
                 AW'($urandom_range(0, 7)),
                 $urandom(),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 29) == 0),
                 AW'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
